// File: rtl/div_restoring_seq.sv
// Sequential restoring divider: unsigned N-bit dividend / divisor, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero short-circuits straight to the done cycle.
module div_restoring_seq #(
    parameter int unsigned N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state, state_n;
    logic [N-1:0]  d, d_n;
    logic [N-1:0]  q, q_n;
    // The partial remainder is always below D between steps, so its top bit
    // is never set and only the low N bits are held.
    logic [N-1:0]  r, r_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  quotient_n, remainder_n;
    logic          busy_n, done_n, div_by_zero_n;

    logic [N:0]    t, s;

    // Trial subtraction of D from the shifted remainder by two's-complement addition.
    assign t = {r, q[N-1]};
    assign s = t + ~{1'b0, d} + (N + 1)'(1);

    always_comb begin
        state_n       = state;
        d_n           = d;
        q_n           = q;
        r_n           = r;
        cnt_n         = cnt;
        quotient_n    = quotient;
        remainder_n   = remainder;
        busy_n        = busy;
        done_n        = 1'b0;
        div_by_zero_n = div_by_zero;

        case (state)
            S_IDLE: begin
                if (start) begin
                    busy_n = 1'b1;
                    if (divisor != '0) begin
                        d_n           = divisor;
                        q_n           = dividend;
                        r_n           = '0;
                        cnt_n         = '0;
                        div_by_zero_n = 1'b0;
                        state_n       = S_RUN;
                    end else begin
                        quotient_n    = '1;
                        remainder_n   = dividend;
                        div_by_zero_n = 1'b1;
                        done_n        = 1'b1;
                        state_n       = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (!s[N]) begin
                    r_n = s[N-1:0];
                    q_n = {q[N-2:0], 1'b1};
                end else begin
                    r_n = t[N-1:0];
                    q_n = {q[N-2:0], 1'b0};
                end
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(N - 1)) begin
                    quotient_n  = q_n;
                    remainder_n = r_n;
                    done_n      = 1'b1;
                    state_n     = S_DONE;
                end
            end
            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            d           <= '0;
            q           <= '0;
            r           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            d           <= d_n;
            q           <= q_n;
            r           <= r_n;
            cnt         <= cnt_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
            busy        <= busy_n;
            done        <= done_n;
            div_by_zero <= div_by_zero_n;
        end
    end

endmodule
